// File: rtl/br_pkg.sv
// Shared definitions for the branch resolve unit: funct3 branch codes and FSM state encoding.
package br_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } br_state_e;

endpackage

// File: rtl/br_cond_decode.sv
// Combinational branch-condition decode: comparator select, taken flag and illegal funct3 detect.
module br_cond_decode
  import br_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       is_branch,
  input  logic       BrEq,
  input  logic       BrLT,
  output logic       taken,
  output logic       BrUn,
  output logic       illegal
);

  assign BrUn = is_branch & funct3[1];

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = BrEq;
      F3_BNE:  taken = !BrEq;
      F3_BLT:  taken = BrLT;
      F3_BGE:  taken = !BrLT;
      F3_BLTU: taken = BrLT;
      F3_BGEU: taken = !BrLT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution with registered PC redirect and timed flush.
// Optional statistics counters are compiled in with BRANCH_STATS_EN.
module branch_resolve_unit
  import br_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            BrUn,
  input  logic            BrEq,
  input  logic            BrLT,
  output logic            redir_valid,
  input  logic            redir_ready,
  output logic [XLEN-1:0] redir_pc,
  output logic            flush_o,
  output logic            illegal_br
`ifdef BRANCH_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_taken,
  output logic [CNT_W-1:0] stat_mispred
`endif
);

  localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;

  br_state_e       state, state_next;
  logic [3:0]      flush_cnt;
  logic            cond_taken, cond_illegal;
  logic            sel_jalr, sel_jal, sel_br;
  logic            taken_p0, mispredict_p0, accept_p0;
  logic [XLEN-1:0] target_p0, actual_pc_p0;

  br_cond_decode u_cond (
    .funct3    (ex_funct3),
    .is_branch (ex_is_branch),
    .BrEq      (BrEq),
    .BrLT      (BrLT),
    .taken     (cond_taken),
    .BrUn      (BrUn),
    .illegal   (cond_illegal)
  );

  // Stage p0: resolve outcome against prediction (jalr > jal > branch)
  always_comb begin
    sel_jalr      = ex_is_jalr;
    sel_jal       = !ex_is_jalr & ex_is_jal;
    sel_br        = !ex_is_jalr & !ex_is_jal & ex_is_branch;
    taken_p0      = sel_jalr | sel_jal | (sel_br & cond_taken);
    target_p0     = sel_jalr ? {ex_target[XLEN-1:1], 1'b0} : ex_target;
    actual_pc_p0  = taken_p0 ? target_p0 : ex_pc + XLEN'(4);
    mispredict_p0 = (taken_p0 != ex_pred_taken) | (taken_p0 & (target_p0 != ex_pred_target));
    accept_p0     = ex_valid & ex_ready;
  end

  // Stage p1: redirect FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept_p0 && mispredict_p0) state_next = REDIRECT;
      REDIRECT: if (redir_ready) state_next = (FLUSH_CYCLES > 0) ? FLUSH : IDLE;
      FLUSH:    if (flush_cnt == 4'd0) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    ex_ready    = (state == IDLE);
    redir_valid = (state == REDIRECT);
    flush_o     = (state == FLUSH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redir_pc   <= '0;
      flush_cnt  <= 4'd0;
      illegal_br <= 1'b0;
    end else begin
      illegal_br <= accept_p0 & sel_br & cond_illegal;
      if (state == IDLE && accept_p0 && mispredict_p0)
        redir_pc <= actual_pc_p0;
      if (state == REDIRECT && redir_ready)
        flush_cnt <= FLUSH_LOAD;
      else if (state == FLUSH && flush_cnt != 4'd0)
        flush_cnt <= flush_cnt - 4'd1;
    end
  end

`ifdef BRANCH_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches <= '0;
      stat_taken    <= '0;
      stat_mispred  <= '0;
    end else if (stat_clr) begin
      stat_branches <= '0;
      stat_taken    <= '0;
      stat_mispred  <= '0;
    end else if (accept_p0) begin
      if (sel_br)        stat_branches <= sat_inc(stat_branches);
      if (taken_p0)      stat_taken    <= sat_inc(stat_taken);
      if (mispredict_p0) stat_mispred  <= sat_inc(stat_mispred);
    end
  end
`endif

endmodule
